hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Hazard/stall controller for the 5-stage MIPS pipeline, directly downstream of the D-stage Tuse/Tnew decoder.
- Consumes the decoder's per-instruction tuse_rs/tuse_rt/res_d classification plus the D-stage register numbers.
- Keeps its own pipelined record (write register, result class) of the instructions in E, M and W.
- Raises stall when a D-stage operand is not yet forwardable, or when HI/LO is busy with a mult/div.
- Exports the E/M/W records so the forwarding muxes can select sources.

Parameters:
- RES_NW, 0, result-class code: no register write
- RES_ALU, 1, result-class code: ALU result, ready end of E
- RES_DM, 2, result-class code: load data, ready end of M
- RES_PC, 3, result-class code: link address (jal/jalr), ready at D
- RES_OTHER, 4, result-class code: lui-type immediate, ready at D
- MULT_CYCLES, 5, busy cycles after a mult/multu issues in E
- DIV_CYCLES, 10, busy cycles after a div/divu issues in E

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- tuse_rs_d  in  2  rs Tuse of D instr (3 = rs unused)
- tuse_rt_d  in  2  rt Tuse of D instr (3 = rt unused)
- res_d  in  3  result class of D instr
- rs_d  in  5  rs field of D instr
- rt_d  in  5  rt field of D instr
- a3_d  in  5  destination register of D instr (31 for jal)
- md_use_d  in  1  D instr reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
- md_start_e  in  1  E instr is mult/multu/div/divu
- md_div_e  in  1  qualifies md_start_e: 1 = div/divu
- stall  out  1  freeze PC and IF/ID; bubble into ID/EX
- a3_e, a3_m, a3_w  out  5 each  destination register of E/M/W record (0 = none)
- res_e, res_m, res_w  out  3 each  result class of E/M/W record
- md_busy  out  1  HI/LO unit busy (busy counter non-zero)

Behaviour:
- Reset, synchronous on the clk edge while reset=1: all a3_* = 0, all res_* = RES_NW, busy counter = 0, md_busy = 0. stall is combinational and is therefore 0 after reset.
- Record pipeline, every clk:
  - W <= M, M <= E.
  - E <= {a3_d, res_d} when stall=0; E <= bubble {0, RES_NW} when stall=1.
  - A D record with res_d = RES_NW, or with a3_d = 0, is stored as a3 = 0.
- Tnew, combinational, saturating at 0:
  - tnew_e: ALU→1, DM→2, PC/OTHER/NW→0.
  - tnew_m: DM→1, else 0.
  - W records always have Tnew 0.
- Data stall term (rs); the rt term is identical with rt_d/tuse_rt_d:
  - stall_rs = (rs_d != 0) & ((a3_e == rs_d & tnew_e > tuse_rs_d) | (a3_m == rs_d & tnew_m > tuse_rs_d)).
  - tuse = 3 never stalls.
  - Register $0 never stalls.
- Mult/div busy counter:
  - md_start_e = 1 loads MULT_CYCLES, or DIV_CYCLES when md_div_e = 1.
  - Otherwise the counter decrements while non-zero.
  - md_busy = (counter != 0).
  - stall_md = md_use_d & (md_start_e | md_busy).
  - md_start_e during an active count reloads the counter (restart).
- stall = stall_rs | stall_rt | stall_md.
- Boundary rules:
  - A stalled D instruction never enters E; only the bubble does.
  - M/W records keep advancing during a stall.
  - When both E and M match the same register, the younger record (E) decides the hazard.
  - reset asserted mid-stall or mid-count clears everything next edge.
  - After reset deasserts, stall depends only on current inputs.

Test Plan:
- lw $1 (res DM, a3=1) in D, then addu with rs=1, tuse_rs=1 → stall=1 for exactly 1 cycle; bubble in E; then M record a3_m=1, res_m=DM, stall=0.
- lw $2, then beq with rt=2, tuse_rt=0 → stall=1 for 2 consecutive cycles; beq leaves D on the 3rd.
- addu $0 (a3=0) followed by an instr reading rs=0 with tuse 0 → stall=0 throughout; a3_e=0.
- jal (res PC, a3=31), then jr $31 (tuse_rs=0) → stall=0 (Tnew 0); a3_e=31, res_e=PC.
- mult in E (md_start_e=1), then mflo in D (md_use_d=1) → stall=1 for 1+5=6 cycles; md_busy high for 5; repeat with div (md_div_e=1) → 11 cycles.
- reset=1 asserted during the 2nd cycle of the beq stall → next edge all a3_*=0, res_*=RES_NW, md_busy=0; stall follows current inputs only.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline.
// Tracks (destination, result class) of the instructions in E, M and W.
// Stalls D when an operand is not yet forwardable or when HI/LO is busy.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   tuse_rs_d, tuse_rt_d  operand Tuse of the D instruction (3 = unused)
//   res_d, rs_d, rt_d     result class and source registers of the D instruction
//   a3_d                  destination register of the D instruction
//   md_use_d              D instruction touches HI/LO
//   md_start_e, md_div_e  E instruction starts a mult (0) or div (1)
//   stall                 combinational freeze of PC and IF/ID, bubble into E
//   a3_e/m/w, res_e/m/w   pipelined records for the forwarding muxes
//   md_busy               HI/LO unit busy
module hazard_stall_ctrl #(
   parameter int unsigned RES_NW      = 0,
   parameter int unsigned RES_ALU     = 1,
   parameter int unsigned RES_DM      = 2,
   parameter int unsigned RES_PC      = 3,
   parameter int unsigned RES_OTHER   = 4,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] tuse_rs_d,
   input  logic [1:0] tuse_rt_d,
   input  logic [2:0] res_d,
   input  logic [4:0] rs_d,
   input  logic [4:0] rt_d,
   input  logic [4:0] a3_d,
   input  logic       md_use_d,
   input  logic       md_start_e,
   input  logic       md_div_e,
   output logic       stall,
   output logic [4:0] a3_e,
   output logic [4:0] a3_m,
   output logic [4:0] a3_w,
   output logic [2:0] res_e,
   output logic [2:0] res_m,
   output logic [2:0] res_w,
   output logic       md_busy
);

   localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [4:0]       a3_e_q, a3_m_q, a3_w_q;
   logic [2:0]       res_e_q, res_m_q, res_w_q;
   logic [4:0]       a3_e_d;
   logic [2:0]       res_e_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             md_busy_q;
   logic [1:0]       tnew_e, tnew_m;
   logic             stall_rs, stall_rt, stall_md;

   // Cycles until an E-stage result becomes forwardable.
   function automatic logic [1:0] tnew_of_e(input logic [2:0] res);
      logic [1:0] t;
      t = 2'd0;
      case (res)
         3'(RES_ALU):   t = 2'd1;
         3'(RES_DM):    t = 2'd2;
         3'(RES_PC):    t = 2'd0;
         3'(RES_OTHER): t = 2'd0;
         default:       t = 2'd0;
      endcase
      return t;
   endfunction

   always_comb begin
      tnew_e = tnew_of_e(res_e_q);
      tnew_m = (res_m_q == 3'(RES_DM)) ? 2'd1 : 2'd0;
   end

   // Operand hazards; the younger E record shadows an M record to the same register.
   always_comb begin
      stall_rs = 1'b0;
      stall_rt = 1'b0;
      if (rs_d != 5'd0 && tuse_rs_d != 2'd3) begin
         if (a3_e_q == rs_d)      stall_rs = (tnew_e > tuse_rs_d);
         else if (a3_m_q == rs_d) stall_rs = (tnew_m > tuse_rs_d);
      end
      if (rt_d != 5'd0 && tuse_rt_d != 2'd3) begin
         if (a3_e_q == rt_d)      stall_rt = (tnew_e > tuse_rt_d);
         else if (a3_m_q == rt_d) stall_rt = (tnew_m > tuse_rt_d);
      end
      stall_md = md_use_d & (md_start_e | md_busy_q);
      stall    = stall_rs | stall_rt | stall_md;
   end

   // Next E record: a bubble while stalled; non-writers are normalised to a3 = 0.
   always_comb begin
      a3_e_d  = 5'd0;
      res_e_d = 3'(RES_NW);
      if (!stall) begin
         res_e_d = res_d;
         a3_e_d  = (res_d == 3'(RES_NW)) ? 5'd0 : a3_d;
      end
   end

   // HI/LO busy counter; a new start always reloads.
   always_comb begin
      cnt_d = cnt_q;
      if (md_start_e)             cnt_d = md_div_e ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      else if (cnt_q != '0)       cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a3_e_q    <= 5'd0;
         a3_m_q    <= 5'd0;
         a3_w_q    <= 5'd0;
         res_e_q   <= 3'(RES_NW);
         res_m_q   <= 3'(RES_NW);
         res_w_q   <= 3'(RES_NW);
         cnt_q     <= '0;
         md_busy_q <= 1'b0;
      end else begin
         a3_e_q    <= a3_e_d;
         res_e_q   <= res_e_d;
         a3_m_q    <= a3_e_q;
         res_m_q   <= res_e_q;
         a3_w_q    <= a3_m_q;
         res_w_q   <= res_m_q;
         cnt_q     <= cnt_d;
         md_busy_q <= (cnt_d != '0);
      end
   end

   assign a3_e    = a3_e_q;
   assign a3_m    = a3_m_q;
   assign a3_w    = a3_w_q;
   assign res_e   = res_e_q;
   assign res_m   = res_m_q;
   assign res_w   = res_w_q;
   assign md_busy = md_busy_q;

endmodule
